poly_tone_pwm: RTL and testbench
================================

Name: poly_tone_pwm

Overview:
Parametrised polyphonic tone generator driving the board audio jack. It runs NUM_VOICES independent square-wave voices, each with its own period, volume and enable. Voice settings are double-buffered, so a retune takes effect only at the voice's period boundary and never glitches. Active voices are summed and converted to a 1-bit audio stream by a first-order sigma-delta modulator; the top level turns that stream into the open-drain AUD_PWM pad.

Parameters:
NUM_VOICES, 4, number of tone voices (>=1)
PERIOD_W, 24, width of the voice period in clk cycles
VOL_W, 4, width of the per-voice volume
CH_W, $clog2(NUM_VOICES) (min 1), width of the channel select
MIX_W, VOL_W+$clog2(NUM_VOICES) (min VOL_W+1), width of the mix sum

Ports:
clk  in  1  system clock (100 MHz)
resetn  in  1  synchronous active-low reset
cfg_wr  in  1  single-cycle configuration write strobe
cfg_ch  in  CH_W  target voice
cfg_period  in  PERIOD_W  new period, in clk cycles
cfg_volume  in  VOL_W  new volume
cfg_en  in  1  new voice enable
mute  in  1  forces the mix to 0
amp_en  in  1  amplifier enable request
voice_phase  out  NUM_VOICES  current square-wave phase of each voice (for LEDs)
cfg_pending  out  NUM_VOICES  shadow write waiting for the period boundary
pdm_out  out  1  sigma-delta audio bit; the top drives the pad to z when 1, else 0
aud_sd  out  1  amplifier shutdown_n, a registered copy of amp_en

Behaviour:
- Every register updates on posedge clk. While resetn=0, everything clears: counters, active and shadow period/volume/enable, pending, mix, accumulator, pdm_out, aud_sd. All outputs read 0 on the first cycle after reset.
- Voice i holds active registers P_i, V_i, E_i and a counter cnt_i.
  - A voice is live when E_i=1 and P_i>=2.
  - While live, cnt_i counts 0..P_i-1 and then wraps to 0.
  - While not live, cnt_i is held at 0.
  - voice_phase[i] = live & (cnt_i < (P_i>>1)). An odd period gives a low half one cycle longer than the high half.
- Configuration writes:
  - When cfg_wr=1 and cfg_ch<NUM_VOICES, {cfg_period, cfg_volume, cfg_en} is loaded into the shadow of voice cfg_ch and pending[cfg_ch] is set.
  - A write with cfg_ch>=NUM_VOICES is ignored.
  - A second write before the shadow is applied overwrites the shadow; the last write wins.
- Applying the shadow:
  - If the voice is not live, the shadow is applied on the cycle after it is written.
  - If the voice is live, the shadow is applied on the edge where cnt_i==P_i-1. The counter goes to 0 and the new values govern from that cycle on.
  - Applying the shadow clears pending.
  - If a write coincides with the wrap cycle of the same voice, the incoming cfg values are applied directly and pending stays 0.
- Mix register, 1 cycle:
  - mix <= mute ? 0 : sum over i of (voice_phase[i] ? V_i : 0), computed as an unsigned MIX_W-bit value.
  - Full scale NUM_VOICES*(2^VOL_W-1) is less than 2^MIX_W, so the sum never overflows.
- Sigma-delta modulator:
  - acc is MIX_W bits.
  - {pdm_out, acc} <= acc + mix, a (MIX_W+1)-bit add whose carry becomes pdm_out.
  - For a constant mix M, exactly M ones appear in every 2^MIX_W consecutive cycles.
- Latency from a voice_phase change to the first affected pdm_out is 2 cycles.
- aud_sd <= amp_en, 1 cycle.
- Reset mid-operation: the next edge returns the block to the reset state, and any pending shadows are discarded.

Decomposition:
- Package poly_tone_pkg holds:
  - default widths;
  - function clog2_min1;
  - the constant VOICE_SILENT_PERIOD=2 (minimum live period).
- Sub-module tone_voice, instantiated NUM_VOICES times by a generate loop, contains:
  - the shadow and active registers;
  - the pending flag;
  - the counter and wrap/apply logic.
  - It outputs phase and weighted amplitude.
- The top holds the address decode, the adder tree, the mix register, the sigma-delta modulator and aud_sd.

Test Plan:
1. Hold resetn=0 for 3 cycles, then release -> pdm_out, aud_sd, voice_phase, cfg_pending all 0; with no writes, pdm_out stays 0 for 200 cycles.
2. With ch0 idle, write ch0 period=8, vol=15, en=1 -> ch0 applies the next cycle and pending never rises; voice_phase[0] is high for 4 cycles and low for 4, repeating; with ch0 phase forced high (period=2^20), pdm_out has exactly 15 ones per 64 cycles (MIX_W=6).
3. While ch0 runs period 8, write period=4 at cnt=2 -> pending[0]=1 until cnt=7; the old 8-cycle waveform completes, then the 4-cycle waveform starts; pending[0] clears on the same edge.
4. Write all 4 voices with period=2^20, vol=15, en=1 -> mix=60 and pdm_out has 60 ones per 64 cycles; asserting mute gives pdm_out=0 within 2 cycles.
5. Write period=1, en=1 to ch1 -> voice_phase[1] stays 0; with NUM_VOICES=3, a write to ch=3 leaves all state unchanged.
6. Pulse resetn low for 1 cycle while ch0 runs with a pending shadow -> the next cycle shows all outputs and pending at 0, and the shadow is not applied afterwards.

Source files
------------

// File: rtl/poly_tone_pkg.sv
// rtl/poly_tone_pkg.sv - shared widths, constants and helpers for the polyphonic tone PWM
package poly_tone_pkg;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_PERIOD_W   = 24;
    localparam int DEF_VOL_W      = 4;

    // Periods below this cannot form a square wave, so the voice stays silent.
    localparam int VOICE_SILENT_PERIOD = 2;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tone_voice.sv
// rtl/tone_voice.sv - one square-wave voice with double-buffered period/volume/enable
module tone_voice
    import poly_tone_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int VOL_W    = DEF_VOL_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wr,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [VOL_W-1:0]    cfg_volume,
    input  logic                cfg_en,
    output logic                phase,
    output logic [VOL_W-1:0]    amp,
    output logic                pending
);

    logic [PERIOD_W-1:0] sh_period;
    logic [VOL_W-1:0]    sh_volume;
    logic                sh_en;
    logic [PERIOD_W-1:0] period;
    logic [VOL_W-1:0]    volume;
    logic                en;
    logic [PERIOD_W-1:0] cnt;
    logic                live;
    logic                wrap;

    assign live  = en && (period >= PERIOD_W'(VOICE_SILENT_PERIOD));
    assign wrap  = live && (cnt == period - PERIOD_W'(1));
    assign phase = live && (cnt < (period >> 1));
    assign amp   = phase ? volume : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh_period <= '0;
            sh_volume <= '0;
            sh_en     <= 1'b0;
            period    <= '0;
            volume    <= '0;
            en        <= 1'b0;
            cnt       <= '0;
            pending   <= 1'b0;
        end else if (wrap) begin
            // Period boundary: a same-cycle write beats the older shadow.
            cnt     <= '0;
            pending <= 1'b0;
            if (wr) begin
                sh_period <= cfg_period;
                sh_volume <= cfg_volume;
                sh_en     <= cfg_en;
                period    <= cfg_period;
                volume    <= cfg_volume;
                en        <= cfg_en;
            end else if (pending) begin
                period <= sh_period;
                volume <= sh_volume;
                en     <= sh_en;
            end
        end else if (live) begin
            cnt <= cnt + PERIOD_W'(1);
            if (wr) begin
                sh_period <= cfg_period;
                sh_volume <= cfg_volume;
                sh_en     <= cfg_en;
                pending   <= 1'b1;
            end
        end else begin
            // An idle voice has no boundary to wait for.
            cnt     <= '0;
            pending <= 1'b0;
            if (wr) begin
                sh_period <= cfg_period;
                sh_volume <= cfg_volume;
                sh_en     <= cfg_en;
                period    <= cfg_period;
                volume    <= cfg_volume;
                en        <= cfg_en;
            end else if (pending) begin
                period <= sh_period;
                volume <= sh_volume;
                en     <= sh_en;
            end
        end
    end

endmodule

// File: rtl/poly_tone_pwm.sv
// rtl/poly_tone_pwm.sv - polyphonic square-wave mixer with first-order sigma-delta output
module poly_tone_pwm
    import poly_tone_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int PERIOD_W   = DEF_PERIOD_W,
    parameter int VOL_W      = DEF_VOL_W,
    parameter int CH_W       = clog2_min1(NUM_VOICES),
    parameter int MIX_W      = VOL_W + clog2_min1(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cfg_wr,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [PERIOD_W-1:0]   cfg_period,
    input  logic [VOL_W-1:0]      cfg_volume,
    input  logic                  cfg_en,
    input  logic                  mute,
    input  logic                  amp_en,
    output logic [NUM_VOICES-1:0] voice_phase,
    output logic [NUM_VOICES-1:0] cfg_pending,
    output logic                  pdm_out,
    output logic                  aud_sd
);

    logic [VOL_W-1:0] amp [NUM_VOICES];
    logic [MIX_W-1:0] mix_next;
    logic [MIX_W-1:0] mix;
    logic [MIX_W-1:0] acc;
    logic [MIX_W:0]   acc_sum;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        logic wr_sel;

        // Channels at or above NUM_VOICES never match, so those writes drop.
        assign wr_sel = cfg_wr && (int'(cfg_ch) == i);

        tone_voice #(
            .PERIOD_W (PERIOD_W),
            .VOL_W    (VOL_W)
        ) u_voice (
            .clk        (clk),
            .resetn     (resetn),
            .wr         (wr_sel),
            .cfg_period (cfg_period),
            .cfg_volume (cfg_volume),
            .cfg_en     (cfg_en),
            .phase      (voice_phase[i]),
            .amp        (amp[i]),
            .pending    (cfg_pending[i])
        );
    end

    always_comb begin
        mix_next = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            mix_next = mix_next + MIX_W'(amp[i]);
        end
        if (mute) begin
            mix_next = '0;
        end
    end

    assign acc_sum = {1'b0, acc} + {1'b0, mix};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mix     <= '0;
            acc     <= '0;
            pdm_out <= 1'b0;
            aud_sd  <= 1'b0;
        end else begin
            mix     <= mix_next;
            acc     <= acc_sum[MIX_W-1:0];
            pdm_out <= acc_sum[MIX_W];
            aud_sd  <= amp_en;
        end
    end

endmodule

// File: tb/tb_poly_tone_pwm.sv
// tb/tb_poly_tone_pwm.sv - self-checking bench for poly_tone_pwm
module tb_poly_tone_pwm;

    localparam int NV = 4;
    localparam int PW = 24;
    localparam int VW = 4;
    localparam int CW = 3;
    localparam int MW = 6;
    localparam int BIG_PERIOD = 1 << 20;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cfg_wr;
    logic [CW-1:0] cfg_ch;
    logic [PW-1:0] cfg_period;
    logic [VW-1:0] cfg_volume;
    logic          cfg_en;
    logic          mute;
    logic          amp_en;
    logic [NV-1:0] voice_phase;
    logic [NV-1:0] cfg_pending;
    logic          pdm_out;
    logic          aud_sd;

    always #5 clk = ~clk;

    poly_tone_pwm #(
        .NUM_VOICES (NV),
        .PERIOD_W   (PW),
        .VOL_W      (VW),
        .CH_W       (CW),
        .MIX_W      (MW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_volume  (cfg_volume),
        .cfg_en      (cfg_en),
        .mute        (mute),
        .amp_en      (amp_en),
        .voice_phase (voice_phase),
        .cfg_pending (cfg_pending),
        .pdm_out     (pdm_out),
        .aud_sd      (aud_sd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what each voice is playing, what it will play next,
    // and the running mixer/modulator values as plain integers.
    int m_p [NV];
    int m_v [NV];
    int m_e [NV];
    int m_cnt [NV];
    int s_p [NV];
    int s_v [NV];
    int s_e [NV];
    int m_pend [NV];
    int m_mix;
    int m_acc;
    int m_pdm;
    int m_sd;

    function automatic bit m_live(int i);
        return (m_e[i] != 0) && (m_p[i] >= 2);
    endfunction

    function automatic bit m_phase(int i);
        return m_live(i) && (m_cnt[i] < m_p[i] / 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_p[i] = 0; m_v[i] = 0; m_e[i] = 0; m_cnt[i] = 0;
            s_p[i] = 0; s_v[i] = 0; s_e[i] = 0; m_pend[i] = 0;
        end
        m_mix = 0; m_acc = 0; m_pdm = 0; m_sd = 0;
    endtask

    task automatic model_step();
        int sum;
        int total;
        if (!resetn) begin
            model_reset();
            return;
        end
        sum = 0;
        for (int i = 0; i < NV; i++) begin
            if (m_phase(i)) sum += m_v[i];
        end
        total = m_acc + m_mix;
        m_pdm = (total >= (1 << MW)) ? 1 : 0;
        m_acc = total % (1 << MW);
        m_mix = mute ? 0 : sum;
        m_sd  = amp_en ? 1 : 0;
        for (int i = 0; i < NV; i++) begin
            bit hit;
            hit = cfg_wr && (int'(cfg_ch) == i);
            if (hit) begin
                s_p[i] = int'(cfg_period); s_v[i] = int'(cfg_volume); s_e[i] = int'(cfg_en);
            end
            if (m_live(i) && m_cnt[i] == m_p[i] - 1) begin
                if (hit || m_pend[i] != 0) begin
                    m_p[i] = s_p[i]; m_v[i] = s_v[i]; m_e[i] = s_e[i];
                end
                m_pend[i] = 0;
                m_cnt[i]  = 0;
            end else if (m_live(i)) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (hit) m_pend[i] = 1;
            end else begin
                if (hit || m_pend[i] != 0) begin
                    m_p[i] = s_p[i]; m_v[i] = s_v[i]; m_e[i] = s_e[i];
                end
                m_pend[i] = 0;
                m_cnt[i]  = 0;
            end
        end
    endtask

    function automatic logic [9:0] model_vec();
        logic [9:0] v;
        for (int i = 0; i < NV; i++) begin
            v[6 + i] = m_phase(i);
            v[2 + i] = (m_pend[i] != 0);
        end
        v[1] = (m_pdm != 0);
        v[0] = (m_sd != 0);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick_chk();
        tick();
        check("model", 32'({voice_phase, cfg_pending, pdm_out, aud_sd}), 32'(model_vec()));
    endtask

    task automatic write_voice(input int ch, input int per, input int vol, input int en);
        cfg_ch     = CW'(ch);
        cfg_period = PW'(per);
        cfg_volume = VW'(vol);
        cfg_en     = en[0];
        cfg_wr     = 1'b1;
        tick_chk();
        cfg_wr     = 1'b0;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        tick_chk();
        resetn = 1'b1;
    endtask

    typedef struct {
        int       vol [NV];
        bit [3:0] en;
        bit       mute;
        int       exp_ones;
    } mix_vec_t;

    mix_vec_t vecs [7];

    initial begin
        int ones;

        vecs[0] = '{vol: '{15, 0, 0, 0},   en: 4'b0001, mute: 1'b0, exp_ones: 15};
        vecs[1] = '{vol: '{15, 15, 15, 15}, en: 4'b1111, mute: 1'b0, exp_ones: 60};
        vecs[2] = '{vol: '{1, 2, 3, 4},     en: 4'b1111, mute: 1'b0, exp_ones: 10};
        vecs[3] = '{vol: '{15, 15, 15, 15}, en: 4'b0101, mute: 1'b0, exp_ones: 30};
        vecs[4] = '{vol: '{9, 9, 9, 9},     en: 4'b1111, mute: 1'b1, exp_ones: 0};
        vecs[5] = '{vol: '{0, 0, 0, 0},     en: 4'b1111, mute: 1'b0, exp_ones: 0};
        vecs[6] = '{vol: '{15, 3, 0, 8},    en: 4'b1011, mute: 1'b0, exp_ones: 26};

        model_reset();
        resetn = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_period = '0;
        cfg_volume = '0; cfg_en = 1'b0; mute = 1'b0; amp_en = 1'b0;

        // Reset state and idle silence
        for (int k = 0; k < 3; k++) tick_chk();
        resetn = 1'b1;
        check("reset_phase", 32'(voice_phase), 32'h0);
        check("reset_pending", 32'(cfg_pending), 32'h0);
        check("reset_pdm", 32'(pdm_out), 32'h0);
        check("reset_aud_sd", 32'(aud_sd), 32'h0);
        ones = 0;
        for (int k = 0; k < 200; k++) begin
            tick_chk();
            ones += int'(pdm_out);
        end
        check("idle_ones", 32'(ones), 32'd0);

        // Idle voice takes a write immediately, 4 high / 4 low
        amp_en = 1'b1;
        write_voice(0, 8, 15, 1);
        for (int k = 0; k < 16; k++) begin
            check("p8_phase", 32'(voice_phase[0]), 32'((k % 8) < 4));
            check("p8_pending", 32'(cfg_pending[0]), 32'h0);
            tick_chk();
        end
        check("aud_sd_on", 32'(aud_sd), 32'h1);

        // Retune mid-period: old waveform completes, then period 4
        tick_chk();
        tick_chk();
        write_voice(0, 4, 15, 1);
        for (int k = 3; k < 8; k++) begin
            check("retune_pending", 32'(cfg_pending[0]), 32'h1);
            check("retune_old_phase", 32'(voice_phase[0]), 32'(k < 4));
            tick_chk();
        end
        for (int k = 0; k < 12; k++) begin
            check("retune_cleared", 32'(cfg_pending[0]), 32'h0);
            check("p4_phase", 32'(voice_phase[0]), 32'((k % 4) < 2));
            tick_chk();
        end

        // Density table: ones per 2^MIX_W cycles equals the mix value
        foreach (vecs[v]) begin
            pulse_reset();
            mute = vecs[v].mute;
            for (int i = 0; i < NV; i++) begin
                write_voice(i, BIG_PERIOD, vecs[v].vol[i], int'(vecs[v].en[i]));
            end
            for (int k = 0; k < 4; k++) tick_chk();
            ones = 0;
            for (int k = 0; k < 64; k++) begin
                tick_chk();
                ones += int'(pdm_out);
            end
            check($sformatf("density_%0d", v), 32'(ones), 32'(vecs[v].exp_ones));
            mute = 1'b0;
        end

        // Mute silences the output within 2 cycles
        pulse_reset();
        for (int i = 0; i < NV; i++) write_voice(i, BIG_PERIOD, 15, 1);
        for (int k = 0; k < 4; k++) tick_chk();
        mute = 1'b1;
        tick_chk();
        tick_chk();
        for (int k = 0; k < 20; k++) begin
            check("mute_pdm", 32'(pdm_out), 32'h0);
            tick_chk();
        end
        mute = 1'b0;

        // Period 1 is silent; out-of-range channel is ignored
        pulse_reset();
        write_voice(1, 1, 15, 1);
        for (int k = 0; k < 10; k++) begin
            check("p1_silent", 32'(voice_phase[1]), 32'h0);
            tick_chk();
        end
        write_voice(5, 8, 15, 1);
        for (int k = 0; k < 10; k++) begin
            check("bad_ch_phase", 32'(voice_phase), 32'h0);
            check("bad_ch_pending", 32'(cfg_pending), 32'h0);
            tick_chk();
        end

        // Reset discards a pending shadow
        pulse_reset();
        write_voice(0, 8, 15, 1);
        tick_chk();
        tick_chk();
        write_voice(0, 4, 7, 1);
        check("pre_reset_pending", 32'(cfg_pending[0]), 32'h1);
        resetn = 1'b0;
        tick_chk();
        check("mid_reset_outs", 32'({voice_phase, cfg_pending, pdm_out, aud_sd}), 32'h0);
        resetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick_chk();
            check("post_reset_phase", 32'(voice_phase[0]), 32'h0);
            check("post_reset_pending", 32'(cfg_pending[0]), 32'h0);
        end

        // Randomised traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            cfg_wr     = ($urandom_range(0, 3) == 0);
            cfg_ch     = CW'($urandom_range(0, 7));
            cfg_period = PW'($urandom_range(0, 20));
            cfg_volume = VW'($urandom_range(0, 15));
            cfg_en     = ($urandom_range(0, 3) != 0);
            mute       = ($urandom_range(0, 15) == 0);
            amp_en     = $urandom_range(0, 1) != 0;
            resetn     = ($urandom_range(0, 199) != 0);
            tick_chk();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
